// File: rtl/sig_dump_ctrl.sv
// Signature-dump controller: snoops begin/end/flag stores, then streams the
// signature word range out of ROM over a valid/ready port, with an idle watchdog.
module sig_dump_ctrl #(
    parameter logic [31:0] BEGIN_ADDR  = 32'h0000_0008,
    parameter logic [31:0] END_ADDR    = 32'h0000_000C,
    parameter logic [31:0] FLAG_ADDR   = 32'h0000_0010,
    parameter int unsigned TIMEOUT_CYC = 25000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    output logic        sig_valid_o,
    output logic [31:0] sig_data_o,
    input  logic        sig_ready_i,
    output logic        done_o,
    output logic        timeout_o,
    output logic        busy_o,
    output logic [15:0] word_cnt_o
);

    localparam int unsigned AW   = 32;
    localparam int unsigned CW   = 16;
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_OUT,
        S_DONE,
        S_TMO
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   beg_q, beg_d;
    logic [AW-1:0]   end_q, end_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   data_q, data_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            mem_req_q, sig_valid_q, done_q, timeout_q, busy_q;
    logic [AW-1:0]   mem_addr_q, sig_data_q;

    logic            flag_go;
    logic [AW-1:0]   ptr_next;

    assign flag_go  = we_i && (waddr_i == FLAG_ADDR) && (wdata_i == 32'd1);
    assign ptr_next = ptr_q + 32'd4;

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        beg_d   = beg_q;
        end_d   = end_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (we_i && (waddr_i == BEGIN_ADDR)) beg_d = {wdata_i[31:2], 2'b00};
                if (we_i && (waddr_i == END_ADDR))   end_d = {wdata_i[31:2], 2'b00};
                if (wd_q != WD_W'(TIMEOUT_CYC)) wd_d = wd_q + WD_W'(1);
                // A flag write on the expiry cycle takes priority over the timeout
                if (flag_go) begin
                    if (beg_q < end_q) begin
                        state_d = S_READ;
                        ptr_d   = beg_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (wd_d == WD_W'(TIMEOUT_CYC)) begin
                    state_d = S_TMO;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                data_d  = mem_rdata_i;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (sig_ready_i) begin
                    cnt_d   = cnt_q + CW'(1);
                    ptr_d   = ptr_next;
                    state_d = (ptr_next >= end_q) ? S_DONE : S_READ;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_TMO:   state_d = S_TMO;
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beg_q       <= '0;
            end_q       <= '0;
            ptr_q       <= '0;
            data_q      <= '0;
            wd_q        <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            sig_valid_q <= 1'b0;
            sig_data_q  <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beg_q       <= beg_d;
            end_q       <= end_d;
            ptr_q       <= ptr_d;
            data_q      <= data_d;
            wd_q        <= wd_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= (state_d == S_READ);
            mem_addr_q  <= (state_d == S_READ) ? ptr_d : '0;
            sig_valid_q <= (state_d == S_OUT);
            sig_data_q  <= (state_d == S_OUT) ? data_d : '0;
            done_q      <= (state_d == S_DONE);
            timeout_q   <= (state_d == S_TMO);
            busy_q      <= (state_d == S_READ) || (state_d == S_WAIT) || (state_d == S_OUT);
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign sig_valid_o = sig_valid_q;
    assign sig_data_o  = sig_data_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = busy_q;
    assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Directed bench for sig_dump_ctrl: ROM model, handshake monitor, per-scenario tasks.
module tb_sig_dump_ctrl;

    localparam logic [31:0] BEG_A  = 32'h0000_0008;
    localparam logic [31:0] END_A  = 32'h0000_000C;
    localparam logic [31:0] FLAG_A = 32'h0000_0010;
    localparam logic [31:0] WA     = 32'hA5A5_0001;
    localparam logic [31:0] WB     = 32'hB6B6_0002;
    localparam logic [31:0] WC     = 32'hC7C7_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [31:0] waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i = '0;
    logic        sig_valid_o;
    logic [31:0] sig_data_o;
    logic        sig_ready_i = 1'b1;
    logic        done_o, timeout_o, busy_o;
    logic [15:0] word_cnt_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] rom [0:255];
    logic [31:0] got_data [$];
    logic [31:0] got_addr [$];
    int          valid_cycles = 0;

    sig_dump_ctrl #(.TIMEOUT_CYC(50)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
        .sig_valid_o(sig_valid_o), .sig_data_o(sig_data_o), .sig_ready_i(sig_ready_i),
        .done_o(done_o), .timeout_o(timeout_o), .busy_o(busy_o), .word_cnt_o(word_cnt_o)
    );

    always #5 clk = ~clk;

    // One-cycle-latency ROM; garbage when not requested
    always @(posedge clk) begin
        if (mem_req_o) mem_rdata_i <= rom[mem_addr_o[9:2]];
        else           mem_rdata_i <= 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (sig_valid_o) valid_cycles++;
        if (sig_valid_o && sig_ready_i) got_data.push_back(sig_data_o);
        if (mem_req_o) got_addr.push_back(mem_addr_o);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_addr.delete();
        valid_cycles = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        we_i = 1'b0;
        sig_ready_i = 1'b1;
        step();
        step();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        step();
        we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done_o !== 1'b1 && cycles < budget) begin
            step();
            cycles++;
        end
        checks++;
        if (done_o !== 1'b1) begin failures++; $display("FAIL wait_done: done_o not seen within %0d cycles", budget); end
    endtask

    task automatic check_abc(input string tag);
        logic [31:0] exp_d [3];
        logic [31:0] exp_a [3];
        exp_d = '{WA, WB, WC};
        exp_a = '{32'h100, 32'h104, 32'h108};
        checks++;
        if (got_data.size() != 3 || got_addr.size() != 3) begin
            failures++;
            $display("FAIL %s_count: words=%0d reqs=%0d expected 3/3", tag, got_data.size(), got_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_data[i] !== exp_d[i] || got_addr[i] !== exp_a[i]) begin
                    failures++;
                    $display("FAIL %s_word%0d: data=%h addr=%h expected data=%h addr=%h",
                             tag, i, got_data[i], got_addr[i], exp_d[i], exp_a[i]);
                end
            end
        end
        checks++;
        if (word_cnt_o !== 16'd3 || done_o !== 1'b1 || busy_o !== 1'b0 || timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_final: cnt=%0d done=%b busy=%b tmo=%b expected 3/1/0/0",
                     tag, word_cnt_o, done_o, busy_o, timeout_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_req_o, mem_addr_o, sig_valid_o, sig_data_o} !== 66'd0) begin
            failures++;
            $display("FAIL reset_stream: req=%b addr=%h valid=%b data=%h expected all 0",
                     mem_req_o, mem_addr_o, sig_valid_o, sig_data_o);
        end
        checks++;
        if ({done_o, timeout_o, busy_o, word_cnt_o} !== 19'd0) begin
            failures++;
            $display("FAIL reset_status: done=%b tmo=%b busy=%b cnt=%0d expected all 0",
                     done_o, timeout_o, busy_o, word_cnt_o);
        end
    endtask

    task automatic test_normal();
        int cyc;
        do_reset();
        write(BEG_A, 32'h100);
        write(END_A, 32'h10C);
        write(FLAG_A, 32'd1);
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL normal_first_req: req=%b addr=%h busy=%b expected 1/00000100/1", mem_req_o, mem_addr_o, busy_o);
        end
        step();
        checks++;
        if (mem_req_o !== 1'b0 || sig_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL normal_wait: req=%b valid=%b expected 0/0", mem_req_o, sig_valid_o);
        end
        step();
        checks++;
        if (sig_valid_o !== 1'b1 || sig_data_o !== WA) begin
            failures++;
            $display("FAIL normal_first_valid: valid=%b data=%h expected 1/%h", sig_valid_o, sig_data_o, WA);
        end
        wait_done(30, cyc);
        checks++;
        if (cyc != 7) begin
            failures++;
            $display("FAIL normal_latency: done after %0d more cycles expected 7", cyc);
        end
        check_abc("normal");
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset();
        write(BEG_A, 32'h100);
        write(END_A, 32'h10E);
        write(FLAG_A, 32'd1);
        for (int i = 0; i < 4; i++) step();
        sig_ready_i = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (sig_valid_o !== 1'b1 || sig_data_o !== WB || mem_req_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: valid=%b data=%h req=%b expected 1/%h/0", i, sig_valid_o, sig_data_o, mem_req_o, WB);
            end
            step();
        end
        sig_ready_i = 1'b1;
        checks++;
        if (sig_valid_o !== 1'b1 || sig_data_o !== WB || word_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL bp_release: valid=%b data=%h cnt=%0d expected 1/%h/1", sig_valid_o, sig_data_o, word_cnt_o, WB);
        end
        wait_done(30, cyc);
        check_abc("bp");
    endtask

    task automatic test_empty();
        logic [31:0] begs [2];
        begs = '{32'h200, 32'h208};
        for (int t = 0; t < 2; t++) begin
            do_reset();
            write(BEG_A, begs[t]);
            write(END_A, 32'h200);
            write(FLAG_A, 32'd1);
            checks++;
            if (done_o !== 1'b1 || busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
                failures++;
                $display("FAIL empty%0d_done: done=%b busy=%b req=%b expected 1/0/0", t, done_o, busy_o, mem_req_o);
            end
            for (int i = 0; i < 4; i++) step();
            checks++;
            if (valid_cycles != 0 || got_addr.size() != 0 || word_cnt_o !== 16'd0 || done_o !== 1'b1) begin
                failures++;
                $display("FAIL empty%0d_quiet: valid_cycles=%0d reqs=%0d cnt=%0d done=%b expected 0/0/0/1",
                         t, valid_cycles, got_addr.size(), word_cnt_o, done_o);
            end
        end
    endtask

    task automatic test_ignored();
        int cyc;
        do_reset();
        write(BEG_A, 32'h180);
        write(BEG_A, 32'h100);
        write(END_A, 32'h10C);
        write(FLAG_A, 32'd2);
        step(); step();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || got_addr.size() != 0) begin
            failures++;
            $display("FAIL ign_flag2: busy=%b done=%b reqs=%0d expected 0/0/0", busy_o, done_o, got_addr.size());
        end
        write(FLAG_A, 32'd1);
        write(BEG_A, 32'h300);
        write(END_A, 32'h400);
        wait_done(30, cyc);
        check_abc("ign");
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 49; i++) step();
        checks++;
        if (timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL tmo_early: timeout=%b at cycle 49 expected 0", timeout_o);
        end
        step();
        checks++;
        if (timeout_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL tmo_rise: timeout=%b done=%b busy=%b at cycle 50 expected 1/0/0", timeout_o, done_o, busy_o);
        end
        write(BEG_A, 32'h100);
        write(END_A, 32'h10C);
        write(FLAG_A, 32'd1);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (timeout_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0 || got_addr.size() != 0) begin
            failures++;
            $display("FAIL tmo_sticky: timeout=%b done=%b busy=%b reqs=%0d expected 1/0/0/0",
                     timeout_o, done_o, busy_o, got_addr.size());
        end
    endtask

    task automatic test_timeout_race();
        int cyc;
        do_reset();
        write(BEG_A, 32'h100);
        write(END_A, 32'h10C);
        for (int i = 0; i < 47; i++) step();
        write(FLAG_A, 32'd1);
        checks++;
        if (busy_o !== 1'b1 || timeout_o !== 1'b0 || mem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL race_flag_wins: busy=%b timeout=%b req=%b expected 1/0/1", busy_o, timeout_o, mem_req_o);
        end
        wait_done(30, cyc);
        check_abc("race");
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_reset();
        write(BEG_A, 32'h100);
        write(END_A, 32'h10C);
        write(FLAG_A, 32'd1);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (sig_valid_o !== 1'b1 || sig_data_o !== WB) begin
            failures++;
            $display("FAIL mid_pre: valid=%b data=%h expected 1/%h", sig_valid_o, sig_data_o, WB);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({mem_req_o, mem_addr_o, sig_valid_o, sig_data_o, done_o, timeout_o, busy_o, word_cnt_o} !== 85'd0) begin
            failures++;
            $display("FAIL mid_abort: req=%b addr=%h valid=%b data=%h done=%b tmo=%b busy=%b cnt=%0d expected all 0",
                     mem_req_o, mem_addr_o, sig_valid_o, sig_data_o, done_o, timeout_o, busy_o, word_cnt_o);
        end
        rst = 1'b0;
        clear_mon();
        write(BEG_A, 32'h100);
        write(END_A, 32'h10C);
        write(FLAG_A, 32'd1);
        wait_done(30, cyc);
        check_abc("rerun");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hD000_0000 | 32'(i);
        rom[64] = WA;
        rom[65] = WB;
        rom[66] = WC;
        test_reset();
        test_normal();
        test_backpressure();
        test_empty();
        test_ignored();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sig_dump_ctrl.md
# sig_dump_ctrl

Synthesizable signature-dump controller for RISC-V compliance runs, sitting directly downstream of the SoC's data RAM and instruction ROM. It snoops core stores to three fixed RAM words: signature begin address, signature end address and end-of-test flag. When the flag is written with 1, it reads the word range [begin, end) out of ROM through a one-cycle-latency read port. Each word is delivered on a valid/ready stream to the host or file-writer side. A cycle-count watchdog flags runs that never finish.

## Interface
- `BEGIN_ADDR`, 32'h0000_0008, byte address of the begin-signature word (RAM word 2)
- `END_ADDR`, 32'h0000_000C, byte address of the end-signature word (RAM word 3)
- `FLAG_ADDR`, 32'h0000_0010, byte address of the end-of-test flag word (RAM word 4)
- `TIMEOUT_CYC`, 25000, cycles after reset without a flag before timeout (500 µs at 50 MHz)
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — synchronous, active-high reset
- `we_i` in 1 — core store strobe (snooped, never stalled)
- `waddr_i` in 32 — store byte address
- `wdata_i` in 32 — store data
- `mem_req_o` out 1 — ROM read request, one cycle per word
- `mem_addr_o` out 32 — ROM byte address, bits [1:0] always 0
- `mem_rdata_i` in 32 — ROM data, valid the cycle after `mem_req_o`
- `sig_valid_o` out 1 — signature word valid
- `sig_data_o` out 32 — signature word
- `sig_ready_i` in 1 — consumer accepts the word when high with `sig_valid_o`
- `done_o` out 1 — sticky, dump complete
- `timeout_o` out 1 — sticky, watchdog expired
- `busy_o` out 1 — dump in progress (READ, WAIT or OUT)
- `word_cnt_o` out 16 — words transferred so far

## Operation
- Registers: `beg_q`, `end_q` (32b), `ptr_q` (32b), `data_q` (32b), `wd_q` (watchdog), `cnt_q` (16b).
- Snoop: in IDLE, `we_i` with `waddr_i==BEGIN_ADDR` loads `beg_q`; `waddr_i==END_ADDR` loads `end_q`. Both are stored with bits [1:0] cleared. Later writes overwrite the stored value.
- Flag: in IDLE, `we_i` with `waddr_i==FLAG_ADDR` and `wdata_i==1` starts the dump. Other flag values are ignored. All snooped writes are ignored outside IDLE.
- FSM states: IDLE, READ, WAIT, OUT, DONE, TMO.
  - IDLE → READ on a valid flag write if `beg_q < end_q` (unsigned); `ptr_q <= beg_q`.
  - IDLE → DONE on a valid flag write if `beg_q >= end_q`. This is a zero-word dump.
  - READ: `mem_req_o=1`, `mem_addr_o=ptr_q`; go to WAIT.
  - WAIT: capture `mem_rdata_i` into `data_q`; go to OUT.
  - OUT: `sig_valid_o=1`, `sig_data_o=data_q`. Hold until `sig_ready_i`.
    - On the handshake: `cnt_q++` and `ptr_q += 4`.
    - If `ptr_q+4 >= end_q`, go to DONE; else go to READ.
  - DONE: `done_o=1`; terminal until reset.
  - TMO: `timeout_o=1`; terminal until reset.
- Watchdog:
  - Increments every cycle in IDLE and saturates at `TIMEOUT_CYC`.
  - Reaching `TIMEOUT_CYC` in IDLE → TMO.
  - A valid flag write in the same cycle as expiry wins: the dump starts.
  - The watchdog is frozen outside IDLE.
- Pointer arithmetic is 32-bit unsigned. `end_q` not word-aligned is truncated at load.
- `word_cnt_o` wraps at 16 bits (not expected in practice).

## Timing
- Reset: all registers are 0, state is IDLE, and every output is 0 (`mem_addr_o`, `sig_data_o`, `word_cnt_o` included).
- Reset mid-dump aborts immediately; the next cycle is IDLE with all outputs 0.
- Flag write sampled at edge N:
  - `mem_req_o` high in cycle N+1.
  - Data captured at edge N+2.
  - `sig_valid_o` high from cycle N+3.
- Per-word latency with `sig_ready_i` held high: 3 cycles (READ, WAIT, OUT).
- `sig_valid_o` and `sig_data_o` stay stable while `sig_ready_i` is low. Valid never drops without a handshake.
- `done_o` rises the cycle after the final handshake, or the cycle after the flag write for a zero-word dump.
- `busy_o` = state in {READ, WAIT, OUT}.
- `mem_req_o` is a single-cycle pulse per word and never asserts outside READ.

## Test plan
- Normal dump: begin=0x100, end=0x10C, ROM words 0x40..0x42 = A, B, C; flag=1; ready high → exactly 3 words A, B, C, `word_cnt_o`=3, `done_o` high; `mem_addr_o` sequence 0x100, 0x104, 0x108.
- Backpressure: same setup, `sig_ready_i` low for 5 cycles on word B → B held stable, no extra `mem_req_o`, final count 3.
- Empty/inverted range: begin=end=0x200, then begin=0x208/end=0x200 across resets; flag=1 → `done_o` next cycle, zero `sig_valid_o` pulses.
- Ignored writes: flag=2 → stays IDLE; flag=1 → dump starts; begin rewritten during the dump → addresses unaffected.
- Timeout: no flag written, `TIMEOUT_CYC`=50 → `timeout_o` rises at cycle 50 after reset, `done_o` stays 0; a later flag write is ignored.
- Reset mid-dump: assert `rst` during OUT of word 2 → all outputs 0 next cycle; a rerun with a new flag write produces the full sequence from begin.
